// File: rtl/fdivsqrt_iter_ctrl_pkg.sv
// Shared types, per-format fraction widths and iteration-count helper for the
// divide/sqrt iteration controller.
package fdivsqrt_iter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NF_H = 10;
  localparam int NF_S = 23;
  localparam int NF_D = 52;
  localparam int NF_Q = 112;

  // Cycles needed to retire Nf+3 quotient bits at log2(radix)*divcopies bits per cycle.
  function automatic int iter_count(input int nf, input int radix, input int divcopies);
    int bits;
    bits = ((radix == 4) ? 2 : 1) * divcopies;
    return (nf + 3 + bits - 1) / bits;
  endfunction

endpackage

// File: rtl/fdivsqrt_iter_ctrl_cyclecnt.sv
// Per-format iteration count, presented as N-1 ready to load into the down-counter.
module fdivsqrtcyclecnt
  import fdivsqrt_iter_ctrl_pkg::*;
#(
  parameter int RADIX     = 4,
  parameter int DIVCOPIES = 2,
  parameter int CW        = 6
) (
  input  logic [1:0]    fmt,
  output logic [CW-1:0] nm1
);

  localparam int N_H = iter_count(NF_H, RADIX, DIVCOPIES);
  localparam int N_S = iter_count(NF_S, RADIX, DIVCOPIES);
  localparam int N_D = iter_count(NF_D, RADIX, DIVCOPIES);
  localparam int N_Q = iter_count(NF_Q, RADIX, DIVCOPIES);

  int n;

  always_comb begin
    case (fmt)
      2'b00:   n = N_H;
      2'b01:   n = N_S;
      2'b10:   n = N_D;
      default: n = N_Q;
    endcase
    nm1 = CW'(n - 1);
    // Q is the longest format, so if it fits every format fits.
    assert (RADIX == 2 || RADIX == 4) else $error("fdivsqrtcyclecnt: RADIX must be 2 or 4");
    assert ((N_Q - 1) < (1 << CW)) else $error("fdivsqrtcyclecnt: CW too narrow for Q iteration count");
  end

endmodule

// File: rtl/fdivsqrt_iter_ctrl.sv
// Divide/sqrt recurrence iteration controller: IDLE/BUSY/DONE sequencing with a
// down-counting iteration timer. Early exit on zero residual when FDIVSQRT_EARLY_TERM_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request, Ready=1
// BUSY  | recurrence running, counter counts N-1 down to 0
// DONE  | result valid, held until AckM
module fdivsqrt_iter_ctrl
  import fdivsqrt_iter_ctrl_pkg::*;
#(
  parameter int RADIX     = 4,
  parameter int DIVCOPIES = 2,
  parameter int CW        = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       StartV,
  output logic       Ready,
  input  logic       SqrtE,
  input  logic [1:0] FmtE,
  input  logic       SpecialCaseE,
  input  logic       WZeroE,
  input  logic       FlushE,
  input  logic       AckM,
  output logic       IFDivStartE,
  output logic       FDivBusyE,
  output logic       DoneV,
  output logic       EarlyTermE
);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nm1;
  logic          accept;
  logic          cnt_tc;
  logic          early_exit;

  // Divide and sqrt share the same iteration count.
  logic sqrt_unused;
  assign sqrt_unused = SqrtE;

  fdivsqrtcyclecnt #(
    .RADIX    (RADIX),
    .DIVCOPIES(DIVCOPIES),
    .CW       (CW)
  ) u_cyclecnt (
    .fmt(FmtE),
    .nm1(cnt_nm1)
  );

  assign cnt_tc = (cnt == '0);

`ifdef FDIVSQRT_EARLY_TERM_EN
  logic early_term_q;

  assign early_exit = (state == BUSY) & WZeroE & ~cnt_tc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    early_term_q <= 1'b0;
    else if (accept)                 early_term_q <= 1'b0;
    else if (early_exit && !FlushE)  early_term_q <= 1'b1;
  end

  assign EarlyTermE = early_term_q;
`else
  logic wzero_unused;
  assign wzero_unused = WZeroE;
  assign early_exit   = 1'b0;
  assign EarlyTermE   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SpecialCaseE ? DONE : BUSY;
      BUSY:    if (cnt_tc || early_exit) state_nxt = DONE;
      DONE:    if (AckM) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (FlushE) state_nxt = IDLE;
  end

  always_comb begin
    Ready       = (state == IDLE);
    DoneV       = (state == DONE);
    accept      = StartV & Ready & ~FlushE;
    IFDivStartE = accept;
    FDivBusyE   = accept | (state == BUSY);
  end

  // Loaded with N-1 so BUSY spans exactly N cycles, terminal count at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      cnt <= '0;
    else if (accept)                   cnt <= cnt_nm1;
    else if (state == BUSY && !cnt_tc) cnt <= cnt - CW'(1);
  end

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Scoreboard bench for fdivsqrt_iter_ctrl (RADIX=4, DIVCOPIES=2); honours FDIVSQRT_EARLY_TERM_EN.
module tb_fdivsqrt_iter_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       StartV, SqrtE, SpecialCaseE, WZeroE, FlushE, AckM;
  logic [1:0] FmtE;
  logic       Ready, IFDivStartE, FDivBusyE, DoneV, EarlyTermE;

  typedef struct {
    int   busy;
    logic early;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef FDIVSQRT_EARLY_TERM_EN
  localparam int   ET_BUSY = 6;
  localparam logic ET_FLAG = 1'b1;
`else
  localparam int   ET_BUSY = 15;
  localparam logic ET_FLAG = 1'b0;
`endif

  fdivsqrt_iter_ctrl #(.RADIX(4), .DIVCOPIES(2), .CW(6)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .StartV      (StartV),
    .Ready       (Ready),
    .SqrtE       (SqrtE),
    .FmtE        (FmtE),
    .SpecialCaseE(SpecialCaseE),
    .WZeroE      (WZeroE),
    .FlushE      (FlushE),
    .AckM        (AckM),
    .IFDivStartE (IFDivStartE),
    .FDivBusyE   (FDivBusyE),
    .DoneV       (DoneV),
    .EarlyTermE  (EarlyTermE)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endfunction

  // Monitor: measures each operation and scores it when DoneV rises.
  int   busy_cnt  = 0;
  int   start_cnt = 0;
  logic done_prev = 1'b0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      busy_cnt  = 0;
      start_cnt = 0;
      done_prev = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (Ready && !IFDivStartE) start_cnt = 0;
      if (IFDivStartE) begin
        busy_cnt = 0;
        start_cnt++;
      end
      if (FDivBusyE) busy_cnt++;
      if (DoneV && !done_prev) begin
        check("done_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("busy_cycles", busy_cnt, e.busy);
          check("start_pulses", start_cnt, 1);
          check("done_follows_busy", int'(busy_prev), 1);
          check("early_term_flag", int'(EarlyTermE), int'(e.early));
        end
        start_cnt = 0;
      end
      done_prev = DoneV;
      busy_prev = FDivBusyE;
    end
  end

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!Ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready_timeout"}, int'(Ready), 1);
  endtask

  task automatic issue(input logic [1:0] fmt, input logic sqrt, input logic spc,
                       input int exp_busy);
    @(posedge clk); #1;
    StartV       = 1'b1;
    FmtE         = fmt;
    SqrtE        = sqrt;
    SpecialCaseE = spc;
    exp_q.push_back('{exp_busy, 1'b0});
    @(posedge clk); #1;
    // Scramble operands after the accept; the controller must not look at them.
    StartV       = 1'b0;
    FmtE         = ~fmt;
    SqrtE        = ~sqrt;
    SpecialCaseE = ~spc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset_n = 1'b0;
    StartV = 1'b0; SqrtE = 1'b0; FmtE = 2'b00; SpecialCaseE = 1'b0;
    WZeroE = 1'b0; FlushE = 1'b0; AckM = 1'b1;
    #12;
    check("rst_ready", int'(Ready), 1);
    check("rst_start", int'(IFDivStartE), 0);
    check("rst_busy", int'(FDivBusyE), 0);
    check("rst_done", int'(DoneV), 0);
    check("rst_eterm", int'(EarlyTermE), 0);
    #10 reset_n = 1'b1;

    // Format sweep, divide and sqrt: expected = accept cycle + N.
    issue(2'b10, 1'b0, 1'b0, 15); wait_ready("d_div");
    issue(2'b00, 1'b1, 1'b0, 5);  wait_ready("h_sqrt");
    issue(2'b01, 1'b1, 1'b0, 8);  wait_ready("s_sqrt");
    issue(2'b11, 1'b1, 1'b0, 30); wait_ready("q_sqrt");
    issue(2'b00, 1'b0, 1'b0, 5);  wait_ready("h_div");
    issue(2'b01, 1'b0, 1'b0, 8);  wait_ready("s_div");
    issue(2'b11, 1'b0, 1'b0, 30); wait_ready("q_div");
    issue(2'b10, 1'b1, 1'b0, 15); wait_ready("d_sqrt");
    issue(2'b10, 1'b0, 1'b1, 1);  wait_ready("special");

    // Consumer stalls: result held, new request ignored until after AckM.
    AckM = 1'b0;
    @(posedge clk); #1;
    StartV = 1'b1; FmtE = 2'b00; SqrtE = 1'b0; SpecialCaseE = 1'b0;
    exp_q.push_back('{5, 1'b0});
    @(posedge clk); #1;
    StartV = 1'b0;
    k = 0;
    while (!DoneV && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("ack_done_timeout", int'(DoneV), 1);
    StartV = 1'b1; FmtE = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("ack_hold_done", int'(DoneV), 1);
      check("ack_hold_ready", int'(Ready), 0);
      check("ack_hold_start", int'(IFDivStartE), 0);
    end
    AckM = 1'b1;
    exp_q.push_back('{8, 1'b0});
    @(posedge clk); #1;
    check("ack_restart", int'(IFDivStartE), 1);
    @(posedge clk); #1;
    StartV = 1'b0;
    wait_ready("ack");

    // Flush in BUSY cycle 3: back to IDLE, never done.
    @(posedge clk); #1;
    StartV = 1'b1; FmtE = 2'b10; SpecialCaseE = 1'b0;
    @(posedge clk); #1;
    StartV = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    FlushE = 1'b1;
    check("flush_busy_before", int'(FDivBusyE), 1);
    @(posedge clk); #1;
    FlushE = 1'b0;
    check("flush_busy_idle", int'(Ready), 1);
    check("flush_busy_off", int'(FDivBusyE), 0);
    repeat (20) @(posedge clk);

    // Flush in the request cycle suppresses the accept.
    #1;
    StartV = 1'b1; FlushE = 1'b1; FmtE = 2'b00;
    #1;
    check("flush_start_pulse", int'(IFDivStartE), 0);
    check("flush_start_busy", int'(FDivBusyE), 0);
    @(posedge clk); #1;
    StartV = 1'b0; FlushE = 1'b0;
    check("flush_start_idle", int'(Ready), 1);
    repeat (20) @(posedge clk);

    // Zero residual at BUSY cycle 5 of a D operation.
    @(posedge clk); #1;
    StartV = 1'b1; FmtE = 2'b10; SqrtE = 1'b0; SpecialCaseE = 1'b0;
    exp_q.push_back('{ET_BUSY, ET_FLAG});
    @(posedge clk); #1;
    StartV = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    WZeroE = 1'b1;
    @(posedge clk); #1;
    WZeroE = 1'b0;
    wait_ready("early");
    repeat (3) @(posedge clk);
    #1;
    check("eterm_hold", int'(EarlyTermE), int'(ET_FLAG));

    // Reset mid-operation abandons it; accept clears EarlyTermE.
    @(posedge clk); #1;
    StartV = 1'b1; FmtE = 2'b10;
    @(posedge clk); #1;
    StartV = 1'b0;
    check("eterm_clear", int'(EarlyTermE), 0);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_ready", int'(Ready), 1);
    check("midrst_busy", int'(FDivBusyE), 0);
    check("midrst_done", int'(DoneV), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("midrst_after_ready", int'(Ready), 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
